ahb_lite2apb: RTL and testbench
===============================

# ahb_lite2apb

Single-master AHB-Lite slave to APB master bridge. It sits directly upstream of the APB peripherals (GPIO and its siblings) and turns each AHB-Lite transfer into exactly one APB SETUP/ACCESS sequence. Slave selection among APB peripherals is done by a separate decoder, so this block drives a single `psel`.

## Interface
- `apb_aw`, 32: APB address width; `paddr = haddr[apb_aw-1:0]`, range 1..32.
- `hclk` in 1: the only clock; all logic on rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `haddr` in 32: AHB address.
- `htrans` in 2: AHB transfer type.
- `hsize` in 3: AHB transfer size.
- `hwrite` in 1: AHB write strobe.
- `hwdata` in 32: AHB write data, valid in data phase.
- `hsel` in 1: slave select from the AHB decoder.
- `hready` in 1: global AHB ready.
- `hrdata` out 32: read data.
- `hreadyout` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `paddr` out apb_aw: APB address.
- `pwdata` out 32: APB write data.
- `pwrite` out 1: APB direction.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation
- Accept condition: `hsel & hready & htrans[1]` (NONSEQ/SEQ), sampled in state IDLE or ERR2.
- IDLE/BUSY transfers give a zero-wait OKAY response.
- On accept, the bridge registers `haddr`, `hwrite` and `hsize`.
- If `hsize > 3'b010`, the next state is ERR1 and no APB access is issued.
- Otherwise the next state is WDATA for a write, SETUP for a read.
- All outputs are registered. Every state drives `hrdata` from its holding register.

State outputs and transitions:
- **IDLE**: `hreadyout=1`, `hresp=0`, `psel=0`, `penable=0`.
- **WDATA**: `hreadyout=0`. Latch `hwdata` into `pwdata`. Go to SETUP.
- **SETUP**: `psel=1`, `penable=0`, `hreadyout=0`. Go to ACCESS.
- **ACCESS**: `psel=1`, `penable=1`, `hreadyout=0`.
  - Wait while `pready=0`.
  - On `pready=1` with `pslverr=0`: read → `hrdata <= prdata`; go to IDLE.
  - On `pready=1` with `pslverr=1`: go to ERR1; `hrdata` is unchanged.
- **ERR1**: `hreadyout=0`, `hresp=1`. Go to ERR2.
- **ERR2**: `hreadyout=1`, `hresp=1`.
  - A new accept goes to WDATA/SETUP/ERR1 as in IDLE.
  - Otherwise go to IDLE.

APB rules and boundaries:
- `paddr`, `pwrite`, `pwdata` stay stable from SETUP until ACCESS completes.
- `psel` deasserts in the cycle after completion, except for back-to-back transfers, where it passes through WDATA/SETUP again.
- `penable` is never high for two consecutive transfers without an intervening SETUP.
- `hsel` / `htrans` changes while `hreadyout=0` are ignored.
- Write data is never taken from `hwdata` outside WDATA.
- Reset mid-transfer: all outputs return to reset values at once. The pending APB access is abandoned.

## Timing
- Reset values:
  - State IDLE; `hreadyout=1`.
  - `hresp`, `psel`, `penable`, `pwrite` = 0.
  - `hrdata`, `pwdata`, `paddr` = 0.
- Times below count from T0 = accept cycle, with `pready` tied to 1:
  - Read: SETUP T1, ACCESS T2, `hreadyout=1` with valid `hrdata` at T3 (2 wait states).
  - Write: WDATA T1, SETUP T2, ACCESS T3, `hreadyout=1` at T4 (3 wait states).
- Each cycle of `pready=0` in ACCESS adds one wait state.
- Error: ACCESS completion → ERR1 → ERR2. `hresp=1` for exactly 2 cycles; `hreadyout` is 0 then 1.
- Size error: ERR1 at T1, ERR2 at T2.
- Next transfer: may be accepted in the completion cycle (IDLE/ERR2 with `hreadyout=1`), giving no idle bubble on the AHB side.

## Structure
- Package `ahb_apb_pkg`:
  - `htrans` encodings (IDLE, BUSY, NONSEQ, SEQ).
  - `hresp` encodings (OKAY, ERROR).
  - Bridge state enum: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- No sub-module: one FSM plus address/data holding registers.
- Top-level wrappers instantiate `ahb_lite2apb` ahead of the APB decoder and the `*_apb` peripherals.

## Test plan
- **Write, `pready` tied 1**: NONSEQ write to 0x0000_0004, `hwdata=0x0000_00A5`, `hsize=2` → `psel` high at T2, `penable` at T3, `paddr=0x04`, `pwdata=0xA5`, `pwrite=1`; `hreadyout=1`, `hresp=0` at T4.
- **Read with wait states**: read 0x08, `pready` low 3 cycles, `prdata=0x1234_5678` → ACCESS lasts 4 cycles; `hrdata=0x1234_5678` with `hreadyout=1` at T6.
- **Slave error**: `pslverr=1` with `pready=1` → `hresp=1` for 2 cycles, `hreadyout` 0 then 1; no second APB access.
- **Size error**: `hsize=3` write → `psel` never asserts; ERROR response at T1/T2.
- **Back-to-back**: read then write, second NONSEQ presented in the read's completion cycle → both APB accesses occur in order, each with its own SETUP; IDLE `htrans` leaves `psel=0`.
- **Reset mid-operation**: assert `hresetn=0` during ACCESS → `psel`, `penable` = 0 and `hreadyout=1` immediately (asynchronous); the next transfer after release completes normally.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Largest transfer the 32-bit APB side can carry (word).
  localparam logic [2:0] HSIZE_MAX = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

endpackage

// File: rtl/ahb_lite2apb.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS per AHB transfer.
module ahb_lite2apb
  import ahb_apb_pkg::*;
#(
  parameter int unsigned apb_aw = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  input  logic              hsel,
  input  logic              hready,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [apb_aw-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  bridge_state_e     state_q, state_d;
  logic [31:0]       hrdata_d, pwdata_d;
  logic [apb_aw-1:0] paddr_d;
  logic              pwrite_d, hreadyout_d, hresp_d, psel_d, penable_d;
  logic              accept;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_IDLE;
      hrdata    <= '0;
      pwdata    <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hrdata    <= hrdata_d;
      pwdata    <= pwdata_d;
      paddr     <= paddr_d;
      pwrite    <= pwrite_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      psel      <= psel_d;
      penable   <= penable_d;
    end
  end

  // Next state plus holding registers; bus-phase outputs are decoded from the
  // next state so that they appear registered in the cycle the state is entered.
  always_comb begin
    state_d     = state_q;
    hrdata_d    = hrdata;
    pwdata_d    = pwdata;
    paddr_d     = paddr;
    pwrite_d    = pwrite;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    accept      = hsel & hready &
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          paddr_d  = haddr[apb_aw-1:0];
          pwrite_d = hwrite;
          if (hsize > HSIZE_MAX) state_d = ST_ERR1;
          else if (hwrite)       state_d = ST_WDATA;
          else                   state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        pwdata_d = hwdata;
        state_d  = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = ST_ERR1;
          end else begin
            if (!pwrite) hrdata_d = prdata;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WDATA: hreadyout_d = 1'b0;
      ST_SETUP: begin
        hreadyout_d = 1'b0;
        psel_d      = 1'b1;
      end
      ST_ACCESS: begin
        hreadyout_d = 1'b0;
        psel_d      = 1'b1;
        penable_d   = 1'b1;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ST_ERR2: hresp_d = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite2apb.sv
// Directed bench for ahb_lite2apb: transfer table plus hand-timed corner sequences.
module tb_ahb_lite2apb;
  import ahb_apb_pkg::*;

  logic        hclk, hresetn;
  logic [31:0] haddr, hwdata, hrdata, pwdata, prdata, paddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite, hsel, hready, hreadyout, hresp;
  logic        pwrite, psel, penable, pready, pslverr;

  int checks = 0;
  int errors = 0;

  localparam int unsigned BUDGET = 40;

  typedef struct {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    int          exp_ws;
    logic        exp_resp;
    logic [31:0] exp_hrdata;
    int          exp_setups;
  } vec_t;

  vec_t vecs[8];

  ahb_lite2apb #(.apb_aw(32)) dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hsel(hsel),
    .hready(hready), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Runs one AHB transfer starting at the current negedge (T0) with a simple
  // APB slave model, then checks the outcome against the vector.
  task automatic run_vec(input vec_t v, input string tag);
    int          ws, acc, setups, first_psel;
    logic        done, resp_fin, resp_prev, psel_fin, stable, cap_pwrite;
    logic [31:0] rdata_fin, cap_paddr, cap_pwdata;
    ws = 0; acc = 0; setups = 0; first_psel = 0; done = 1'b0;
    resp_fin = 1'b0; resp_prev = 1'b0; psel_fin = 1'b0; stable = 1'b1;
    rdata_fin = '0; cap_paddr = '0; cap_pwdata = '0; cap_pwrite = 1'b0;
    haddr = v.addr; hwrite = v.write; hsize = v.size; htrans = HTRANS_NONSEQ;
    hsel = 1'b1; hready = 1'b1; hwdata = 32'hDEAD_BEEF; pready = 1'b0; pslverr = 1'b0;
    for (int k = 1; k <= int'(BUDGET) && !done; k++) begin
      @(negedge hclk);
      if (psel && !penable) begin
        setups++;
        if (first_psel == 0) first_psel = k;
        cap_paddr = paddr; cap_pwrite = pwrite; cap_pwdata = pwdata;
      end
      if (psel && penable)
        stable = stable & (paddr == cap_paddr) & (pwrite == cap_pwrite) & (pwdata == cap_pwdata);
      if (hreadyout) begin
        done = 1'b1; ws = k - 1; resp_fin = hresp; rdata_fin = hrdata; psel_fin = psel;
        htrans = HTRANS_IDLE; hsel = 1'b0; hready = 1'b1; pready = 1'b0; pslverr = 1'b0;
      end else begin
        resp_prev = hresp;
        htrans = HTRANS_SEQ; hsel = 1'b1; hready = 1'b0; haddr = 32'hBAD0_0000;
        hwdata = (k == 1) ? v.wdata : 32'hDEAD_BEEF;
        if (psel && penable) begin
          pready  = (acc == v.waits);
          pslverr = pready & v.err;
          prdata  = pready ? v.rdata : 32'h0BAD_0BAD;
          acc++;
        end else begin
          pready = 1'b0; pslverr = 1'b0;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout no hreadyout within %0d cycles", tag, BUDGET);
      htrans = HTRANS_IDLE; hsel = 1'b0; hready = 1'b1; pready = 1'b0;
    end else begin
      chk({tag, " wait_states"}, 32'(ws), 32'(v.exp_ws));
      chk({tag, " hresp_final"}, 32'(resp_fin), 32'(v.exp_resp));
      chk({tag, " hresp_before_final"}, 32'(resp_prev), 32'(v.exp_resp));
      chk({tag, " hrdata"}, rdata_fin, v.exp_hrdata);
      chk({tag, " setup_count"}, 32'(setups), 32'(v.exp_setups));
      chk({tag, " psel_after"}, 32'(psel_fin), 32'd0);
      if (v.exp_setups > 0) begin
        chk({tag, " paddr"}, cap_paddr, v.addr);
        chk({tag, " pwrite"}, 32'(cap_pwrite), 32'(v.write));
        chk({tag, " setup_cycle"}, 32'(first_psel), v.write ? 32'd2 : 32'd1);
        chk({tag, " apb_stable"}, 32'(stable), 32'd1);
        if (v.write) chk({tag, " pwdata"}, cap_pwdata, v.wdata);
      end
    end
  endtask

  initial begin
    vec_t rv;
    //             wr    size   addr           wdata          w  err   rdata          ws resp  exp_hrdata     setups
    vecs[0] = '{1'b1, 3'd2, 32'h0000_0004, 32'h0000_00A5, 0, 1'b0, 32'h0,         3, 1'b0, 32'h0,         1};
    vecs[1] = '{1'b0, 3'd2, 32'h0000_0008, 32'h0,         3, 1'b0, 32'h1234_5678, 5, 1'b0, 32'h1234_5678, 1};
    vecs[2] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         0, 1'b1, 32'hFFFF_0000, 3, 1'b1, 32'h1234_5678, 1};
    vecs[3] = '{1'b1, 3'd3, 32'h0000_0020, 32'h0000_0011, 0, 1'b0, 32'h0,         1, 1'b1, 32'h1234_5678, 0};
    vecs[4] = '{1'b0, 3'd0, 32'h0000_000C, 32'h0,         1, 1'b0, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 1};
    vecs[5] = '{1'b1, 3'd1, 32'h0000_0100, 32'h5A5A_5A5A, 2, 1'b1, 32'h0,         6, 1'b1, 32'hCAFE_F00D, 1};
    vecs[6] = '{1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,         0, 1'b0, 32'hA5A5_0001, 2, 1'b0, 32'hA5A5_0001, 1};
    vecs[7] = '{1'b0, 3'd7, 32'h0000_0044, 32'h0,         0, 1'b0, 32'h0,         1, 1'b1, 32'hA5A5_0001, 0};

    hresetn = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hsize = '0; hwrite = 1'b0;
    hwdata = '0; hsel = 1'b0; hready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge hclk);
    chk("rst hreadyout", 32'(hreadyout), 32'd1);
    chk("rst hresp", 32'(hresp), 32'd0);
    chk("rst psel", 32'(psel), 32'd0);
    chk("rst penable", 32'(penable), 32'd0);
    chk("rst pwrite", 32'(pwrite), 32'd0);
    chk("rst hrdata", hrdata, 32'd0);
    chk("rst pwdata", pwdata, 32'd0);
    chk("rst paddr", paddr, 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Consecutive vectors start in the previous completion cycle (no bubble).
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: read, then write presented in the read's completion cycle.
    @(negedge hclk);
    haddr = 32'h30; hwrite = 1'b0; hsize = 3'd2; htrans = HTRANS_NONSEQ; hsel = 1'b1;
    hready = 1'b1; pready = 1'b1; pslverr = 1'b0; prdata = 32'h1111_2222;
    @(negedge hclk);
    chk("b2b rd setup psel", 32'({psel, penable}), 32'b10);
    htrans = HTRANS_IDLE; hready = 1'b0;
    @(negedge hclk);
    chk("b2b rd access", 32'({psel, penable}), 32'b11);
    @(negedge hclk);
    chk("b2b rd done", 32'({hreadyout, hresp, psel}), 32'b100);
    chk("b2b rd hrdata", hrdata, 32'h1111_2222);
    haddr = 32'h34; hwrite = 1'b1; hsize = 3'd2; htrans = HTRANS_NONSEQ; hready = 1'b1;
    @(negedge hclk);
    chk("b2b wr wdata phase", 32'({hreadyout, psel}), 32'b00);
    hwdata = 32'h77; htrans = HTRANS_IDLE; hready = 1'b0; prdata = 32'h9999_9999;
    @(negedge hclk);
    chk("b2b wr setup", 32'({psel, penable, pwrite}), 32'b101);
    chk("b2b wr paddr", paddr, 32'h34);
    chk("b2b wr pwdata", pwdata, 32'h77);
    hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    chk("b2b wr access", 32'({psel, penable}), 32'b11);
    chk("b2b wr pwdata hold", pwdata, 32'h77);
    @(negedge hclk);
    chk("b2b wr done", 32'({hreadyout, hresp, psel, penable}), 32'b1000);
    chk("b2b wr hrdata kept", hrdata, 32'h1111_2222);
    hsel = 1'b1; htrans = HTRANS_IDLE; hready = 1'b1;
    repeat (2) @(negedge hclk);
    chk("idle htrans psel", 32'({psel, hreadyout}), 32'b01);

    // Reset asserted while the APB access is stalled.
    haddr = 32'h40; hwrite = 1'b0; hsize = 3'd2; htrans = HTRANS_NONSEQ; pready = 1'b0;
    @(negedge hclk);
    htrans = HTRANS_IDLE; hready = 1'b0;
    @(negedge hclk);
    chk("mid access reached", 32'({psel, penable, hreadyout}), 32'b110);
    #2 hresetn = 1'b0;
    #1;
    chk("mid rst psel/penable", 32'({psel, penable}), 32'b00);
    chk("mid rst hreadyout", 32'(hreadyout), 32'd1);
    chk("mid rst paddr", paddr, 32'd0);
    chk("mid rst hrdata", hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1; hsel = 1'b0; hready = 1'b1;
    @(negedge hclk);
    rv = '{1'b0, 3'd2, 32'h0000_0048, 32'h0, 0, 1'b0, 32'h0000_BEEF, 2, 1'b0, 32'h0000_BEEF, 1};
    run_vec(rv, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
